life_sequencer: RTL and testbench

Generation sequencer for the 8x8 Life board: owns the 64-bit grid register and decides every cycle whether it holds, loads the user seed, loads the LFSR pattern, or commits one evolution from the combinational next-generation datapath. Sits between the switch/seed inputs, the LFSR, the evolve datapath and the display driver. It replaces the free-running mux selection with explicit run/pause/single-step control, a generation counter, and auto-halt on stable or extinct boards.

---
 rtl/life_pkg.sv | 13 +
 rtl/life_tick_div.sv | 39 +++
 rtl/life_sequencer.sv | 109 ++++++++++
 tb/tb_life_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared board width and sequencer state encoding for the Life block.
package life_pkg;

  localparam int GRID_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } life_state_t;

endpackage

// File: rtl/life_tick_div.sv
// rtl/life_tick_div.sv - generation tick divider; tick_pulse marks the last cycle of each TICK_DIV window.
module life_tick_div #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick_pulse
);

  localparam int TICK_W = $clog2(TICK_DIV) + 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_d;
  logic              at_last;

  assign at_last    = (tick_q == TICK_LAST);
  assign tick_pulse = en && !clr && at_last;

  always_comb begin
    tick_d = tick_q;
    if (clr) begin
      tick_d = '0;
    end else if (en) begin
      tick_d = at_last ? '0 : tick_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - owns the Life grid register; chooses hold, seed/LFSR load or one evolution per cycle.
module life_sequencer
  import life_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int GEN_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] seed,
  input  logic [GRID_W-1:0] rand_grid,
  input  logic [GRID_W-1:0] next_grid,
  input  logic              load_seed,
  input  logic              load_rand,
  input  logic              run,
  input  logic              step,
  output logic [GRID_W-1:0] grid,
  output logic [GEN_W-1:0]  gen_count,
  output logic [1:0]        state,
  output logic              stable,
  output logic              extinct
);

  life_state_t       state_q, state_d;
  logic [GRID_W-1:0] grid_q, grid_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic              stable_q, stable_d;
  logic              load;
  logic              tick_en;
  logic              tick_pulse;
  logic              commit;

  assign load    = load_seed || load_rand;
  // The divider only counts while free-running; any other cycle rewinds it to zero.
  assign tick_en = (state_q == RUN) && run && !load;

  life_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk        (clk),
    .reset      (reset),
    .clr        (!tick_en),
    .en         (tick_en),
    .tick_pulse (tick_pulse)
  );

  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    commit   = 1'b0;

    if (load) begin
      grid_d   = load_seed ? seed : rand_grid;
      gen_d    = '0;
      stable_d = 1'b0;
      state_d  = PAUSE;
    end else begin
      case (state_q)
        PAUSE: begin
          if (run) begin
            state_d = RUN;
          end else if (step) begin
            commit = 1'b1;
          end
        end
        RUN: begin
          if (!run) begin
            state_d = PAUSE;
          end else begin
            commit = tick_pulse;
          end
        end
        default: ;
      endcase
    end

    if (commit) begin
      grid_d   = next_grid;
      gen_d    = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + GEN_W'(1);
      stable_d = (next_grid == grid_q);
      if ((next_grid == grid_q) || (next_grid == '0)) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grid_q   <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign state     = state_q;
  assign stable    = stable_q;
  assign extinct   = (grid_q == '0);

endmodule

// File: tb/tb_life_sequencer.sv
// tb/tb_life_sequencer.sv - directed bench for life_sequencer with a reference Life evolve function.
module tb_life_sequencer;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_0000_0E00;
  localparam logic [63:0] BLINK_V = 64'h0000_0000_0004_0404;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
  localparam logic [63:0] CELL    = 64'h0000_0000_0000_0001;
  localparam logic [63:0] RANDV   = 64'hDEAD_BEEF_0000_1234;
  localparam logic [63:0] S_IDLE  = 64'd0;
  localparam logic [63:0] S_PAUSE = 64'd1;
  localparam logic [63:0] S_RUN   = 64'd2;
  localparam logic [63:0] S_DONE  = 64'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] seed, rand_grid;
  logic        load_seed, load_rand, run, step;
  logic [63:0] grid, grid2, next_grid, next_grid2;
  logic [15:0] gen_count;
  logic [1:0]  gen_count2;
  logic [1:0]  state, state2;
  logic        stable, stable2, extinct, extinct2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Non-wrapping 8x8 Life rule, bit index = row*8 + col.
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8) begin
              cnt += int'(g[(r + dr) * 8 + c + dc]);
            end
          end
        end
        n[r * 8 + c] = g[r * 8 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  assign next_grid  = life_next(grid);
  assign next_grid2 = life_next(grid2);

  life_sequencer #(.TICK_DIV(4), .GEN_W(16)) u_dut (
    .clk(clk), .reset(reset), .seed(seed), .rand_grid(rand_grid), .next_grid(next_grid),
    .load_seed(load_seed), .load_rand(load_rand), .run(run), .step(step),
    .grid(grid), .gen_count(gen_count), .state(state), .stable(stable), .extinct(extinct)
  );

  life_sequencer #(.TICK_DIV(4), .GEN_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .seed(seed), .rand_grid(rand_grid), .next_grid(next_grid2),
    .load_seed(load_seed), .load_rand(load_rand), .run(run), .step(step),
    .grid(grid2), .gen_count(gen_count2), .state(state2), .stable(stable2), .extinct(extinct2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [63:0] cur;
    reset = 1'b1; seed = '0; rand_grid = RANDV;
    load_seed = 1'b0; load_rand = 1'b0; run = 1'b0; step = 1'b0;
    cyc(3);
    check("rst_grid", grid, 64'd0);
    check("rst_gen", 64'(gen_count), 64'd0);
    check("rst_state", 64'(state), S_IDLE);
    check("rst_extinct", 64'(extinct), 64'd1);
    check("rst_stable", 64'(stable), 64'd0);
    reset = 1'b0;

    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step = i[0];
      cyc(1);
    end
    step = 1'b0; run = 1'b0;
    check("idle_state", 64'(state), S_IDLE);
    check("idle_grid", grid, 64'd0);

    // Blinker free-run: one commit every 4 cycles.
    seed = BLINK_H; load_seed = 1'b1;
    cyc(1);
    load_seed = 1'b0;
    check("ld_grid", grid, BLINK_H);
    check("ld_state", 64'(state), S_PAUSE);
    check("ld_extinct", 64'(extinct), 64'd0);
    run = 1'b1;
    cyc(1);
    check("run_state", 64'(state), S_RUN);
    cur = BLINK_H;
    for (int i = 1; i <= 10; i++) begin
      cyc(3);
      check("run_hold", grid, cur);
      cyc(1);
      cur = (cur == BLINK_H) ? BLINK_V : BLINK_H;
      check("run_grid", grid, cur);
      check("run_gen", 64'(gen_count), 64'(i));
      check("sat_gen", 64'(gen_count2), 64'((i > 3) ? 3 : i));
    end
    check("run10_state", 64'(state), S_RUN);
    check("run10_stable", 64'(stable), 64'd0);
    check("sat_state", 64'(state2), S_RUN);

    // Drop run mid-tick, then re-enter: full TICK_DIV wait before next commit.
    cyc(2);
    run = 1'b0;
    cyc(1);
    check("drop_state", 64'(state), S_PAUSE);
    check("drop_grid", grid, BLINK_H);
    run = 1'b1;
    cyc(1);
    cyc(3);
    check("rerun_hold", grid, BLINK_H);
    check("rerun_gen", 64'(gen_count), 64'd10);
    cyc(1);
    check("rerun_grid", grid, BLINK_V);
    check("rerun_gen1", 64'(gen_count), 64'd11);

    // Simultaneous loads at tick = 2: seed wins, no commit.
    cyc(2);
    seed = BLOCK; load_seed = 1'b1; load_rand = 1'b1;
    cyc(1);
    load_seed = 1'b0; load_rand = 1'b0;
    check("prio_grid", grid, BLOCK);
    check("prio_gen", 64'(gen_count), 64'd0);
    check("prio_state", 64'(state), S_PAUSE);

    // Block is stable: first commit halts in DONE.
    cyc(1);
    check("blk_run", 64'(state), S_RUN);
    cyc(3);
    check("blk_pre_gen", 64'(gen_count), 64'd0);
    cyc(1);
    check("blk_stable", 64'(stable), 64'd1);
    check("blk_state", 64'(state), S_DONE);
    check("blk_gen", 64'(gen_count), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step = ~step;
      run  = (i % 3) != 0;
      cyc(1);
    end
    step = 1'b0; run = 1'b0;
    cyc(1);
    check("done_gen", 64'(gen_count), 64'd1);
    check("done_state", 64'(state), S_DONE);
    check("done_grid", grid, BLOCK);

    // Single cell dies on one step.
    seed = CELL; load_seed = 1'b1;
    cyc(1);
    load_seed = 1'b0;
    check("cell_state", 64'(state), S_PAUSE);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    check("ext_grid", grid, 64'd0);
    check("ext_flag", 64'(extinct), 64'd1);
    check("ext_state", 64'(state), S_DONE);
    check("ext_gen", 64'(gen_count), 64'd1);
    check("ext_stable", 64'(stable), 64'd0);

    // load_rand alone, then a step held for 3 cycles commits 3 generations.
    load_rand = 1'b1;
    cyc(1);
    load_rand = 1'b0;
    check("rand_grid", grid, RANDV);
    check("rand_state", 64'(state), S_PAUSE);
    seed = BLINK_H; load_seed = 1'b1;
    cyc(1);
    load_seed = 1'b0;
    step = 1'b1;
    cyc(3);
    step = 1'b0;
    check("step3_gen", 64'(gen_count), 64'd3);
    check("step3_grid", grid, BLINK_V);
    check("step3_state", 64'(state), S_PAUSE);
    cyc(2);
    check("step_idle_gen", 64'(gen_count), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
